// File: rtl/dtpu_infifo_axis_if.sv
// AXI4-Stream activation channel into the dtpu input FIFO.
// The DMA side drives payload, valid and last; the FIFO drives ready.
interface dtpu_infifo_axis_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dtpu_infifo_axis.sv
// First-word-fall-through FIFO between the PS DMA stream and the core's acc_fifo_read port.
// Head word is {tlast,tdata}; fill level, almost-full and sticky underflow are exported for debug.
module dtpu_infifo_axis #(
  parameter int DATA_WIDTH_FIFO_IN = 64,
  parameter int DEPTH              = 16,
  parameter int AF_THRESHOLD       = 12
) (
  input  logic                        clk,
  input  logic                        aresetn,
  dtpu_infifo_axis_if.slave           s_axis,
  output logic [DATA_WIDTH_FIFO_IN:0] infifo_dout,
  input  logic                        infifo_read,
  output logic                        infifo_is_empty,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        almost_full,
  output logic                        underflow_err,
  input  logic                        clr_err
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int WORD_W = DATA_WIDTH_FIFO_IN + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_THRESHOLD);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
  logic [LVL_W-1:0]  level_r, level_next_s;
  logic [WORD_W-1:0] dout_r, dout_next_s, wr_word_s;
  logic              empty_r, af_r, uf_r, uf_next_s, tready_r, ready_en_r;
  logic              push_s, pop_s, underrun_s;

  assign wr_word_s  = {s_axis.tlast, s_axis.tdata};
  assign push_s     = s_axis.tvalid & tready_r;
  assign pop_s      = infifo_read & ~empty_r;
  assign underrun_s = infifo_read & empty_r;

  // Next-state for pointers, level, head word and sticky error.
  always_comb begin
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    level_next_s  = level_r;
    dout_next_s   = {WORD_W{1'b0}};
    uf_next_s     = uf_r;

    if (push_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    if (push_s && !pop_s) begin
      level_next_s = level_r + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_next_s = level_r - LVL_W'(1);
    end else begin
      level_next_s = level_r;
    end

    // The word being written this edge becomes the head when it lands on the next read slot.
    if (level_next_s == LVL_W'(0)) begin
      dout_next_s = {WORD_W{1'b0}};
    end else if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
      dout_next_s = wr_word_s;
    end else begin
      dout_next_s = mem_r[rd_ptr_next_s];
    end

    if (underrun_s) begin
      uf_next_s = 1'b1;
    end else if (clr_err) begin
      uf_next_s = 1'b0;
    end else begin
      uf_next_s = uf_r;
    end
  end

  // Storage array; contents are don't-care until the level counter covers them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_word_s;
    end
  end

  // Control and output registers; ready_en_r plus tready_r form the reset-release synchroniser.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      dout_r     <= {WORD_W{1'b0}};
      empty_r    <= 1'b1;
      af_r       <= 1'b0;
      uf_r       <= 1'b0;
      tready_r   <= 1'b0;
      ready_en_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_next_s;
      rd_ptr_r   <= rd_ptr_next_s;
      level_r    <= level_next_s;
      dout_r     <= dout_next_s;
      empty_r    <= (level_next_s == LVL_W'(0));
      af_r       <= (level_next_s >= AF_L);
      uf_r       <= uf_next_s;
      tready_r   <= ready_en_r & (level_next_s < DEPTH_L);
      ready_en_r <= 1'b1;
    end
  end

  assign s_axis.tready   = tready_r;
  assign infifo_dout     = dout_r;
  assign infifo_is_empty = empty_r;
  assign level           = level_r;
  assign almost_full     = af_r;
  assign underflow_err   = uf_r;
endmodule
